// File: rtl/fifo_p2_ctrl_if.sv
// Producer/consumer handshake bundle for fifo_p2_ctrl.
// The FIFO controller is the slave; the surrounding logic (or bench) is the master.
interface fifo_p2_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
);
    logic                  wr_valid;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_ready;
    logic [ADDR_WIDTH+1:0] level;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data, level
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data, level
    );
endinterface

// File: rtl/fifo_p2_ctrl.sv
// FIFO controller around an external simple dual-port RAM with registered read,
// plus a 2-entry output register queue so the consumer sees data with no RAM latency.
module fifo_p2_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  resetn,
    fifo_p2_ctrl_if.slave         bus,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   mem_count;
    logic                  inflight;
    logic [1:0]            buf_count;
    logic [DATA_WIDTH-1:0] buf_data [2];

    logic                  wr_ready_int;
    logic                  rd_valid_int;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [2:0]            occ_after_pop;
    logic [1:0]            buf_keep;

    // wr_ready depends only on registered state, never on rd_ready.
    assign wr_ready_int = (mem_count < DEPTH_CNT);
    assign rd_valid_int = (buf_count != 2'd0);

    assign push = bus.wr_valid & wr_ready_int;
    assign pop  = rd_valid_int & bus.rd_ready;

    // Output queue slots that will still be occupied (or claimed by the word in
    // flight) after this cycle's pop; issue only if one slot stays free.
    assign occ_after_pop = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
    assign issue         = (mem_count != '0) && (occ_after_pop < 3'd2);

    assign buf_keep = buf_count - {1'b0, pop};

    assign ram_we         = push;
    assign ram_write_addr = wr_ptr;
    assign ram_data       = bus.wr_data;
    assign ram_read_addr  = rd_ptr;

    assign bus.wr_ready = wr_ready_int;
    assign bus.rd_valid = rd_valid_int;
    assign bus.rd_data  = buf_data[0];
    assign bus.level    = {1'b0, mem_count}
                        + {{(ADDR_WIDTH+1){1'b0}}, inflight}
                        + {{ADDR_WIDTH{1'b0}}, buf_count};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
        end else if (issue) begin
            rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_count <= '0;
        end else begin
            case ({push, issue})
                2'b10:   mem_count <= mem_count + 1'b1;
                2'b01:   mem_count <= mem_count - 1'b1;
                default: mem_count <= mem_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inflight  <= 1'b0;
            buf_count <= 2'd0;
        end else begin
            inflight  <= issue;
            buf_count <= buf_keep + {1'b0, inflight};
        end
    end

    // Data slots carry no reset; the in-flight word lands behind whatever survives the pop.
    always_ff @(posedge clk) begin
        if (pop) begin
            buf_data[0] <= buf_data[1];
        end
        if (inflight) begin
            buf_data[buf_keep[0]] <= ram_q;
        end
    end

    a_buf_bound: assert property (@(posedge clk) disable iff (!resetn)
        buf_count <= 2'd2);
    a_mem_bound: assert property (@(posedge clk) disable iff (!resetn)
        mem_count <= DEPTH_CNT);
    a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
        !(inflight && (buf_keep == 2'd2)));

endmodule

// File: tb/tb_fifo_p2_ctrl.sv
// Directed vector table plus hand sequences (stream, full, reset) and a random scoreboard run.
module tb_fifo_p2_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          resetn;
    logic          ram_we;
    logic [AW-1:0] ram_write_addr;
    logic [DW-1:0] ram_data;
    logic [AW-1:0] ram_read_addr;
    logic [DW-1:0] ram_q;
    logic [DW-1:0] ram_mem [DEPTH];

    int checks   = 0;
    int failures = 0;

    fifo_p2_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fifo_p2_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .bus            (bus),
        .ram_we         (ram_we),
        .ram_write_addr (ram_write_addr),
        .ram_data       (ram_data),
        .ram_read_addr  (ram_read_addr),
        .ram_q          (ram_q)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < DEPTH; i++) ram_mem[i] = 8'hEE;
        ram_q = 8'hEE;
    end

    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_write_addr] <= ram_data;
        ram_q <= ram_mem[ram_read_addr];
    end

    typedef struct {
        logic       wv;
        logic [7:0] wd;
        logic       rr;
        logic       e_wr_ready;
        logic       e_rd_valid;
        logic [7:0] e_rd_data;
        logic [3:0] e_level;
        logic       e_ram_we;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];
    logic [7:0] sb[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wv, input logic [7:0] wd, input logic rr);
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.rd_ready = rr;
    endtask

    task automatic fill(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, base + 8'(i), 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        drive(1'b0, 8'h00, 1'b1);
        while (exp_q.size() > 0 && guard < 40) begin
            #1;
            if (bus.rd_valid) chk(tag, int'(bus.rd_data), int'(exp_q.pop_front()));
            tick();
            guard++;
        end
        chk({tag, " leftover"}, exp_q.size(), 0);
        drive(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_pop, last_pop, nexp, got, stale;

        // wv wd rr | wr_ready rd_valid rd_data level ram_we
        vecs.push_back('{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 4'd1, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 4'd1, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 4'd1, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 4'd1, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 4'd1, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0});
        vecs.push_back('{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1});
        vecs.push_back('{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 8'h00, 4'd1, 1'b1});
        vecs.push_back('{1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 8'h00, 4'd2, 1'b1});
        vecs.push_back('{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 8'h01, 4'd3, 1'b1});
        vecs.push_back('{1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 8'h01, 4'd4, 1'b1});
        vecs.push_back('{1'b1, 8'h06, 1'b0, 1'b1, 1'b1, 8'h01, 4'd5, 1'b1});
        vecs.push_back('{1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 8'h01, 4'd6, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 4'd6, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h01, 4'd6, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h02, 4'd5, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h03, 4'd4, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h04, 4'd3, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h05, 4'd2, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h06, 4'd1, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0});

        resetn = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset rd_valid", int'(bus.rd_valid), 0);
        chk("reset level", int'(bus.level), 0);
        chk("reset wr_ready", int'(bus.wr_ready), 1);
        chk("reset ram_we", int'(ram_we), 0);
        resetn = 1'b1;
        tick();

        foreach (vecs[i]) begin
            drive(vecs[i].wv, vecs[i].wd, vecs[i].rr);
            #1;
            chk($sformatf("v%0d wr_ready", i), int'(bus.wr_ready), int'(vecs[i].e_wr_ready));
            chk($sformatf("v%0d rd_valid", i), int'(bus.rd_valid), int'(vecs[i].e_rd_valid));
            chk($sformatf("v%0d level", i), int'(bus.level), int'(vecs[i].e_level));
            chk($sformatf("v%0d ram_we", i), int'(ram_we), int'(vecs[i].e_ram_we));
            if (vecs[i].e_rd_valid)
                chk($sformatf("v%0d rd_data", i), int'(bus.rd_data), int'(vecs[i].e_rd_data));
            tick();
        end

        // continuous stream: one pop per cycle once the pipeline has filled
        first_pop = -1;
        last_pop  = -1;
        nexp      = 0;
        for (int c = 0; c < 30; c++) begin
            drive(c < 16, 8'(c), 1'b1);
            #1;
            if (c < 16) chk("stream wr_ready", int'(bus.wr_ready), 1);
            if (bus.rd_valid) begin
                chk("stream data", int'(bus.rd_data), nexp);
                nexp++;
                if (first_pop < 0) first_pop = c;
                last_pop = c;
            end
            tick();
        end
        drive(1'b0, 8'h00, 1'b0);
        chk("stream count", nexp, 16);
        chk("stream first pop", first_pop, 3);
        chk("stream span", last_pop - first_pop, 15);

        // full with simultaneous pop and push: push refused, accepted next cycle
        fill(8'h11, 6);
        tick();
        drive(1'b1, 8'h70, 1'b1);
        #1;
        chk("full level", int'(bus.level), 6);
        chk("full wr_ready", int'(bus.wr_ready), 0);
        chk("full head", int'(bus.rd_data), 8'h11);
        tick();
        drive(1'b1, 8'h70, 1'b0);
        #1;
        chk("full next wr_ready", int'(bus.wr_ready), 1);
        chk("full next level", int'(bus.level), 5);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        #1;
        chk("full refill level", int'(bus.level), 6);
        tick();
        exp_q = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h70};
        drain("full drain");
        tick();

        // reset with level 5 and a read in flight
        fill(8'h21, 6);
        tick();
        drive(1'b0, 8'h00, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        #1;
        chk("pre-reset level", int'(bus.level), 5);
        #1;
        resetn = 1'b0;
        #1;
        chk("async rst rd_valid", int'(bus.rd_valid), 0);
        chk("async rst level", int'(bus.level), 0);
        chk("async rst wr_ready", int'(bus.wr_ready), 1);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        drive(1'b1, 8'h3C, 1'b1);
        #1;
        chk("post-rst wr_ready", int'(bus.wr_ready), 1);
        tick();
        drive(1'b0, 8'h00, 1'b1);
        got = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            #1;
            if (bus.rd_valid) begin
                chk("post-rst first data", int'(bus.rd_data), 8'h3C);
                got = 1;
            end
            tick();
        end
        chk("post-rst 3C seen", got, 1);
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (bus.rd_valid) stale++;
            tick();
        end
        chk("post-rst no stale", stale, 0);
        chk("post-rst level", int'(bus.level), 0);

        // random traffic against a queue scoreboard
        sb.delete();
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0);
            #1;
            chk("rand level", int'(bus.level), sb.size());
            if (!bus.wr_ready) chk("rand full level", int'(bus.level >= 4'(DEPTH)), 1);
            if (bus.rd_valid) begin
                if (sb.size() == 0) chk("rand valid while empty", 1, 0);
                else if (bus.rd_ready) chk("rand data", int'(bus.rd_data), int'(sb.pop_front()));
            end
            if (bus.wr_valid && bus.wr_ready) sb.push_back(bus.wr_data);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
